// File: rtl/pmu_pkg.sv
// Shared types and constants for the gated power management unit.
// Output vectors are ordered {powerup, enable, ready}.
package pmu_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        PMU_BOOT    = 3'd0,
        PMU_RUN     = 3'd1,
        PMU_GATED   = 3'd2,
        PMU_WAKE_PU = 3'd3,
        PMU_WAKE_EN = 3'd4
    } pmu_state_e;

    localparam logic [2:0] OUT_ON          = 3'b111;
    localparam logic [2:0] OUT_GATED_DEEP  = 3'b000;
    localparam logic [2:0] OUT_GATED_LIGHT = 3'b100;
    localparam logic [2:0] OUT_WAKE_PU     = 3'b100;
    localparam logic [2:0] OUT_WAKE_EN     = 3'b110;

    // True in the cycle a count completes, or once it already sits at limit.
    function automatic logic cnt_hit(
        input logic             inc,
        input logic [CNT_W-1:0] cnt,
        input int               limit,
        input logic             done
    );
        return done | (inc && (cnt == CNT_W'(limit - 1)));
    endfunction

endpackage

// File: rtl/pmu_gated_if.sv
// Core-side bus of the PMU: stack pointer, idle/wake requests
// and the HFOSC control/status outputs.
interface pmu_gated_if #(
    parameter int WIDTH    = 32,
    parameter int NUM_WAKE = 4
);
    logic [WIDTH-1:0]    rdsp;
    logic                idle_req;
    logic [NUM_WAKE-1:0] wake_evt;
    logic [NUM_WAKE-1:0] wake_mask;
    logic                clkhf_enable;
    logic                clkhf_powerup;
    logic                clk_ready;
    logic                boot_done;
    logic [2:0]          state_out;

    modport master (
        output rdsp, idle_req, wake_evt, wake_mask,
        input  clkhf_enable, clkhf_powerup, clk_ready,
        input  boot_done, state_out
    );

    modport slave (
        input  rdsp, idle_req, wake_evt, wake_mask,
        output clkhf_enable, clkhf_powerup, clk_ready,
        output boot_done, state_out
    );
endinterface

// File: rtl/pmu_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// o_done is high while the count sits at LIMIT.
module pmu_sat_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count,
    output logic         o_done
);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_count = r_cnt;
    assign o_done  = (r_cnt == LIM);
endmodule

// File: rtl/pmu_gated.sv
// Slow-clock PMU: counts boot triggers, then gates HFOSC on idle
// and restores it on masked wake with a timed startup.
module pmu_gated
    import pmu_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] TRIGGER_SP     = 32'h1000,
    parameter int               BOOT_MATCHES   = 2,
    parameter int               IDLE_CYCLES    = 16,
    parameter int               STARTUP_CYCLES = 8,
    parameter int               NUM_WAKE       = 4,
    parameter int               DEEP_SLEEP     = 1
) (
    input logic       slow_clk,
    input logic       reset_n,
    pmu_gated_if.slave bus
);
    logic [WIDTH-1:0] r_sp1;
    logic [WIDTH-1:0] r_sp2;
    logic             r_match;
    pmu_state_e       r_state;
    pmu_state_e       w_nxt;
    logic [2:0]       r_out;
    logic [2:0]       w_out;
    logic             r_boot_done;

    logic             w_match;
    logic             w_evt;
    logic             w_wake;
    logic [CNT_W-1:0] w_boot_cnt;
    logic [CNT_W-1:0] w_idle_cnt;
    logic [CNT_W-1:0] w_su_cnt;
    logic             w_boot_done;
    logic             w_idle_done;
    logic             w_su_done;
    logic             w_boot_inc;
    logic             w_idle_inc;
    logic             w_su_inc;
    logic             w_boot_hit;
    logic             w_idle_hit;
    logic             w_su_hit;

    // Two-stage sample of rdsp; only a fresh match counts as an event.
    assign w_match = (r_sp1 == TRIGGER_SP) && (r_sp2 == TRIGGER_SP);
    assign w_evt   = w_match && !r_match;
    assign w_wake  = |(bus.wake_evt & bus.wake_mask);

    assign w_boot_inc = w_evt && (r_state == PMU_BOOT);
    assign w_idle_inc = bus.idle_req && (r_state == PMU_RUN);
    assign w_su_inc   = (r_state == PMU_WAKE_PU);

    assign w_boot_hit = cnt_hit(w_boot_inc, w_boot_cnt,
                                BOOT_MATCHES, w_boot_done);
    assign w_idle_hit = cnt_hit(w_idle_inc, w_idle_cnt,
                                IDLE_CYCLES, w_idle_done);
    assign w_su_hit   = cnt_hit(w_su_inc, w_su_cnt,
                                STARTUP_CYCLES, w_su_done);

    pmu_sat_counter #(.W(CNT_W), .LIMIT(BOOT_MATCHES)) u_boot_cnt (
        .i_clk   (slow_clk),
        .i_rst_n (reset_n),
        .i_inc   (w_boot_inc),
        .i_clr   (1'b0),
        .o_count (w_boot_cnt),
        .o_done  (w_boot_done)
    );

    pmu_sat_counter #(.W(CNT_W), .LIMIT(IDLE_CYCLES)) u_idle_cnt (
        .i_clk   (slow_clk),
        .i_rst_n (reset_n),
        .i_inc   (w_idle_inc),
        .i_clr   (!w_idle_inc || w_idle_hit),
        .o_count (w_idle_cnt),
        .o_done  (w_idle_done)
    );

    pmu_sat_counter #(.W(CNT_W), .LIMIT(STARTUP_CYCLES)) u_su_cnt (
        .i_clk   (slow_clk),
        .i_rst_n (reset_n),
        .i_inc   (w_su_inc),
        .i_clr   (!w_su_inc),
        .o_count (w_su_cnt),
        .o_done  (w_su_done)
    );

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            PMU_BOOT:    if (w_boot_hit) w_nxt = PMU_RUN;
            PMU_RUN:     if (w_idle_hit && !w_wake) w_nxt = PMU_GATED;
            PMU_GATED: begin
                if (w_wake) begin
                    w_nxt = (DEEP_SLEEP != 0) ? PMU_WAKE_PU
                                              : PMU_WAKE_EN;
                end
            end
            PMU_WAKE_PU: if (w_su_hit) w_nxt = PMU_WAKE_EN;
            PMU_WAKE_EN: w_nxt = PMU_RUN;
            default:     w_nxt = PMU_BOOT;
        endcase
    end

    // Outputs follow the next state so they change with the state register.
    always_comb begin
        w_out = OUT_ON;
        unique case (w_nxt)
            PMU_GATED: w_out = (DEEP_SLEEP != 0) ? OUT_GATED_DEEP
                                                 : OUT_GATED_LIGHT;
            PMU_WAKE_PU: w_out = OUT_WAKE_PU;
            PMU_WAKE_EN: w_out = OUT_WAKE_EN;
            default:     w_out = OUT_ON;
        endcase
    end

    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sp1       <= '0;
            r_sp2       <= '0;
            r_match     <= 1'b0;
            r_state     <= PMU_BOOT;
            r_out       <= OUT_ON;
            r_boot_done <= 1'b0;
        end else begin
            r_sp1       <= bus.rdsp;
            r_sp2       <= r_sp1;
            r_match     <= w_match;
            r_state     <= w_nxt;
            r_out       <= w_out;
            r_boot_done <= r_boot_done | w_boot_hit;
        end
    end

    assign bus.clkhf_powerup = r_out[2];
    assign bus.clkhf_enable  = r_out[1];
    assign bus.clk_ready     = r_out[0];
    assign bus.boot_done     = r_boot_done;
    assign bus.state_out     = r_state;
endmodule

// File: tb/tb_pmu_gated.sv
// Scoreboard bench: deep-sleep and light-sleep PMUs share stimulus;
// expectations are queued with a due cycle and checked on negedge.
module tb_pmu_gated;

    typedef struct {
        int         at;
        bit         light;
        logic [6:0] v;
        string      tag;
    } exp_t;

    localparam logic [2:0] ON = 3'b111;
    localparam logic [2:0] GD = 3'b000;
    localparam logic [2:0] GL = 3'b100;
    localparam logic [2:0] PU = 3'b100;
    localparam logic [2:0] EN = 3'b110;

    logic        clk;
    logic        rst_n;
    logic [31:0] rdsp;
    logic        idle;
    logic [3:0]  wevt;
    logic [3:0]  wmask;
    logic [6:0]  obs_d;
    logic [6:0]  obs_l;
    int          cyc;
    int          n_checks;
    int          n_err;
    exp_t        sb[$];
    exp_t        keep[$];

    pmu_gated_if #(.WIDTH(32), .NUM_WAKE(4)) bus_d ();
    pmu_gated_if #(.WIDTH(32), .NUM_WAKE(4)) bus_l ();

    assign bus_d.rdsp      = rdsp;
    assign bus_d.idle_req  = idle;
    assign bus_d.wake_evt  = wevt;
    assign bus_d.wake_mask = wmask;
    assign bus_l.rdsp      = rdsp;
    assign bus_l.idle_req  = idle;
    assign bus_l.wake_evt  = wevt;
    assign bus_l.wake_mask = wmask;

    assign obs_d = {bus_d.boot_done, bus_d.state_out,
                    bus_d.clkhf_powerup, bus_d.clkhf_enable,
                    bus_d.clk_ready};
    assign obs_l = {bus_l.boot_done, bus_l.state_out,
                    bus_l.clkhf_powerup, bus_l.clkhf_enable,
                    bus_l.clk_ready};

    pmu_gated #(.DEEP_SLEEP(1)) u_deep (
        .slow_clk (clk),
        .reset_n  (rst_n),
        .bus      (bus_d)
    );

    pmu_gated #(.DEEP_SLEEP(0)) u_light (
        .slow_clk (clk),
        .reset_n  (rst_n),
        .bus      (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [6:0] obs,
                         input logic [6:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] v(input bit bd, input int st,
                                     input logic [2:0] o);
        return {bd, st[2:0], o};
    endfunction

    task automatic exp2(input int d, input logic [6:0] vd,
                        input logic [6:0] vl, input string tag);
        sb.push_back('{at: cyc + d, light: 1'b0, v: vd,
                       tag: {tag, "_d"}});
        sb.push_back('{at: cyc + d, light: 1'b1, v: vl,
                       tag: {tag, "_l"}});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].at == cyc)
                check(sb[i].tag, sb[i].light ? obs_l : obs_d, sb[i].v);
            else
                keep.push_back(sb[i]);
        end
        sb = keep;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        rdsp     = '0;
        idle     = 1'b0;
        wevt     = '0;
        wmask    = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_d", obs_d, v(0, 0, ON));
        check("rst_l", obs_l, v(0, 0, ON));
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // first trigger, held: counts once
        rdsp = 32'h1000;
        exp2(3, v(0, 0, ON), v(0, 0, ON), "boot_one");
        exp2(10, v(0, 0, ON), v(0, 0, ON), "boot_held");
        tick(10);
        rdsp = 32'h2000;
        tick(3);
        rdsp = 32'h1000;
        exp2(2, v(0, 0, ON), v(0, 0, ON), "boot_pre");
        exp2(3, v(1, 1, ON), v(1, 1, ON), "boot_done");
        tick(5);

        // 15 idle cycles do not gate
        idle = 1'b1;
        exp2(15, v(1, 1, ON), v(1, 1, ON), "idle15");
        exp2(16, v(1, 1, ON), v(1, 1, ON), "idle15_hold");
        tick(15);
        idle = 1'b0;
        tick(3);

        // 16 idle cycles gate
        idle = 1'b1;
        exp2(15, v(1, 1, ON), v(1, 1, ON), "idle16_pre");
        exp2(16, v(1, 2, GD), v(1, 2, GL), "gated");
        tick(16);
        idle = 1'b0;

        // masked-off wake leaves it gated
        wmask = 4'b0100;
        wevt  = 4'b0001;
        exp2(1, v(1, 2, GD), v(1, 2, GL), "mask_off");
        exp2(3, v(1, 2, GD), v(1, 2, GL), "mask_off_hold");
        tick(3);
        wevt = '0;
        tick(1);

        // enabled wake: deep takes 10 cycles, light 2
        wevt = 4'b0100;
        exp2(1, v(1, 3, PU), v(1, 4, EN), "wake1");
        exp2(2, v(1, 3, PU), v(1, 1, ON), "wake2");
        exp2(8, v(1, 3, PU), v(1, 1, ON), "pu_last");
        exp2(9, v(1, 4, EN), v(1, 1, ON), "wake_en");
        exp2(10, v(1, 1, ON), v(1, 1, ON), "ready");
        tick(1);
        wevt = '0;
        tick(11);

        // wake in the completing idle cycle cancels and clears count
        idle = 1'b1;
        exp2(16, v(1, 1, ON), v(1, 1, ON), "race");
        exp2(31, v(1, 1, ON), v(1, 1, ON), "race_cnt0");
        exp2(32, v(1, 2, GD), v(1, 2, GL), "race_gate");
        tick(15);
        wevt = 4'b0100;
        tick(1);
        wevt = '0;
        tick(16);
        idle = 1'b0;
        tick(2);

        wevt = 4'b0100;
        exp2(10, v(1, 1, ON), v(1, 1, ON), "rewake");
        tick(1);
        wevt = '0;
        tick(11);

        // trigger in RUN is ignored
        rdsp = '0;
        tick(3);
        rdsp = 32'h1000;
        exp2(3, v(1, 1, ON), v(1, 1, ON), "trig_run");
        exp2(5, v(1, 1, ON), v(1, 1, ON), "trig_run2");
        tick(6);

        // reset in the middle of startup
        idle = 1'b1;
        exp2(16, v(1, 2, GD), v(1, 2, GL), "gate2");
        tick(16);
        idle = 1'b0;
        wevt = 4'b0100;
        exp2(1, v(1, 3, PU), v(1, 4, EN), "pu_enter");
        tick(3);
        wevt = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_d", obs_d, v(0, 0, ON));
        check("rst_mid_l", obs_l, v(0, 0, ON));
        tick(2);
        rst_n = 1'b1;
        exp2(3, v(0, 0, ON), v(0, 0, ON), "post_rst");
        tick(4);

        check("sb_empty", 7'(sb.size()), 7'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule
